ama_riscv_fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the deepened pipeline. Tracks destination tags
//  (rd, we, load) of in-flight instructions across FWD_DEPTH stages after ID (stage 1 = EX).

---
 rtl/ama_riscv_fwd_hazard_unit_pkg.sv | 26 ++
 rtl/ama_riscv_fwd_hazard_unit_match.sv | 36 +++
 rtl/ama_riscv_fwd_hazard_unit.sv | 120 ++++++++++++
 tb/tb_ama_riscv_fwd_hazard_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// A tag describes one in-flight instruction: whether it is live, where it writes and
// whether the written value only appears late because the instruction is a load.

package ama_riscv_fwd_hazard_unit_pkg;

  localparam int FWD_SRC_NONE = 0;
  localparam logic [4:0] RF_X0_ZERO = 5'd0;
  localparam int TAG_W = 8;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } fwd_tag_t;

  localparam fwd_tag_t TAG_BUBBLE = '{vld: 1'b0, rd: 5'd0, we: 1'b0, ld: 1'b0};

  // A stage can feed an operand only if it is live, writes a register and that
  // register is the one being read; x0 is hard-wired, so it never matches.
  function automatic logic tag_match(input fwd_tag_t tag, input logic [4:0] rs);
    return tag.vld && tag.we && (tag.rd != RF_X0_ZERO) && (tag.rd == rs);
  endfunction

endpackage

// File: rtl/ama_riscv_fwd_hazard_unit_match.sv
// Per-operand forwarding source selection.
// Looks at every tracked stage and picks the youngest (smallest index) stage that writes
// the operand's register. Also flags a load-use hazard when that youngest producer is a
// load whose data is not yet available at that stage.

module ama_riscv_fwd_match
  import ama_riscv_fwd_hazard_unit_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 2,
  parameter int SRC_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic [FWD_DEPTH*TAG_W-1:0] tag_vec,
  input  logic [4:0]                 rs,
  input  logic                       used,
  output logic [SRC_W-1:0]           src,
  output logic                       hazard
);

  // Scan oldest to youngest so the youngest match is the last one written and wins;
  // an older load therefore can never raise a hazard that a younger producer hides.
  always_comb begin
    fwd_tag_t tag;
    src    = SRC_W'(FWD_SRC_NONE);
    hazard = 1'b0;
    tag    = TAG_BUBBLE;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      tag = fwd_tag_t'(tag_vec[(k-1)*TAG_W +: TAG_W]);
      if (used && tag_match(tag, rs)) begin
        src    = SRC_W'(k);
        hazard = tag.ld && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/ama_riscv_fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the deepened pipeline.
// Keeps a small pipe of destination tags mirroring the stages after ID (stage 1 = EX)
// and, from those tags plus the decoded ID instruction, drives the operand-forwarding
// selects for the ALU, branch compare and store data. When the youngest producer of an
// operand is a load that has not reached LOAD_LAT, ID is held and a bubble enters EX.

module ama_riscv_fwd_hazard_unit
  import ama_riscv_fwd_hazard_unit_pkg::*;
#(
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 2,
  parameter int CNT_W     = 32,
  localparam int SRC_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_ext,
  input  logic             flush_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_id,
  input  logic             reg_we_id,
  input  logic             load_inst_id,
  input  logic             alu_a_sel,
  input  logic             alu_b_sel,
  input  logic             store_inst_id,
  input  logic             branch_inst_id,
  output logic [SRC_W-1:0] fwd_a_src,
  output logic [SRC_W-1:0] fwd_b_src,
  output logic [SRC_W-1:0] bc_a_src,
  output logic [SRC_W-1:0] bcs_b_src,
  output logic             stall_id,
  output logic [CNT_W-1:0] stall_cnt
);

  fwd_tag_t [FWD_DEPTH:1]       tag_q;
  logic [FWD_DEPTH*TAG_W-1:0]   tag_vec;
  logic [SRC_W-1:0]             src_rs1;
  logic [SRC_W-1:0]             src_rs2;
  logic                         haz_rs1;
  logic                         haz_rs2;
  fwd_tag_t                     tag_id;

  assign tag_vec = tag_q;
  assign tag_id  = '{vld: 1'b1, rd: rd_id, we: reg_we_id, ld: load_inst_id};

  ama_riscv_fwd_match #(
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_LAT  (LOAD_LAT),
    .SRC_W     (SRC_W)
  ) u_match_rs1 (
    .tag_vec (tag_vec),
    .rs      (rs1_id),
    .used    (rs1_used_id),
    .src     (src_rs1),
    .hazard  (haz_rs1)
  );

  ama_riscv_fwd_match #(
    .FWD_DEPTH (FWD_DEPTH),
    .LOAD_LAT  (LOAD_LAT),
    .SRC_W     (SRC_W)
  ) u_match_rs2 (
    .tag_vec (tag_vec),
    .rs      (rs2_id),
    .used    (rs2_used_id),
    .src     (src_rs2),
    .hazard  (haz_rs2)
  );

  // A killed ID instruction cannot consume anything, so a flush cancels the stall.
  assign stall_id = (haz_rs1 | haz_rs2) & ~flush_id;

  // Route each operand's source to the muxes that actually read it; everything is
  // parked on "no forward" while ID is stalled so the bubble carries no stale select.
  always_comb begin
    fwd_a_src = SRC_W'(FWD_SRC_NONE);
    fwd_b_src = SRC_W'(FWD_SRC_NONE);
    bc_a_src  = SRC_W'(FWD_SRC_NONE);
    bcs_b_src = SRC_W'(FWD_SRC_NONE);
    if (!stall_id) begin
      if (!alu_a_sel)                     fwd_a_src = src_rs1;
      if (!alu_b_sel)                     fwd_b_src = src_rs2;
      if (branch_inst_id)                 bc_a_src  = src_rs1;
      if (store_inst_id || branch_inst_id) bcs_b_src = src_rs2;
    end
  end

  // Tag pipe advances with the pipeline; an external stall freezes every stage, and a
  // hazard or flush sends a bubble into EX in place of the ID instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        tag_q[k] <= TAG_BUBBLE;
      end
    end else if (!stall_ext) begin
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        tag_q[k] <= tag_q[k-1];
      end
      if (stall_id || flush_id) begin
        tag_q[1] <= TAG_BUBBLE;
      end else begin
        tag_q[1] <= tag_id;
      end
    end
  end

  // Performance counter of cycles lost to load-use stalls; cycles frozen by an
  // external stall are not charged to the hazard, and the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_id && !stall_ext && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ama_riscv_fwd_hazard_unit.sv
// Bench for the forwarding / hazard unit. Two instances share one stimulus stream:
// LOAD_LAT=2 with a 32-bit counter, and LOAD_LAT=3 with a 3-bit counter so the
// saturation path is reachable. A list-of-in-flight-instructions model predicts outputs.

module tb_ama_riscv_fwd_hazard_unit;

  typedef struct packed {
    logic       rs;
    logic       sx;
    logic       fl;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       asel;
    logic       bsel;
    logic       st;
    logic       br;
  } stim_t;

  logic       clk;
  logic       rst;
  logic       stall_ext;
  logic       flush_id;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       rs1_used_id;
  logic       rs2_used_id;
  logic [4:0] rd_id;
  logic       reg_we_id;
  logic       load_inst_id;
  logic       alu_a_sel;
  logic       alu_b_sel;
  logic       store_inst_id;
  logic       branch_inst_id;

  logic [1:0]  a_fa, a_fb, a_ba, a_bb;
  logic        a_st;
  logic [31:0] a_cnt;
  logic [1:0]  b_fa, b_fb, b_ba, b_bb;
  logic        b_st;
  logic [2:0]  b_cnt;
  logic [8:0]  obs_a;
  logic [8:0]  obs_b;

  assign obs_a = {a_fa, a_fb, a_ba, a_bb, a_st};
  assign obs_b = {b_fa, b_fb, b_ba, b_bb, b_st};

  int n_check;
  int n_fail;

  bit       m_vld [2][4];
  bit [4:0] m_rd  [2][4];
  bit       m_we  [2][4];
  bit       m_ld  [2][4];
  int       m_lat [2];
  longint   m_max [2];
  longint   m_cnt [2];
  bit       m_st  [2];
  logic [8:0] exp_out [2];

  ama_riscv_fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(32)) dut_ll2 (
    .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush_id(flush_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_we_id(reg_we_id), .load_inst_id(load_inst_id),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .store_inst_id(store_inst_id), .branch_inst_id(branch_inst_id),
    .fwd_a_src(a_fa), .fwd_b_src(a_fb), .bc_a_src(a_ba), .bcs_b_src(a_bb),
    .stall_id(a_st), .stall_cnt(a_cnt)
  );

  ama_riscv_fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(3), .CNT_W(3)) dut_ll3 (
    .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush_id(flush_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_we_id(reg_we_id), .load_inst_id(load_inst_id),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .store_inst_id(store_inst_id), .branch_inst_id(branch_inst_id),
    .fwd_a_src(b_fa), .fwd_b_src(b_fb), .bc_a_src(b_ba), .bcs_b_src(b_bb),
    .stall_id(b_st), .stall_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t op(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                               input logic u2, input logic [4:0] rd, input logic we,
                               input logic ld, input logic asel, input logic bsel,
                               input logic st, input logic br);
    stim_t s;
    s = '0;
    s.r1 = r1; s.r2 = r2; s.u1 = u1; s.u2 = u2; s.rd = rd; s.we = we; s.ld = ld;
    s.asel = asel; s.bsel = bsel; s.st = st; s.br = br;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rs; stall_ext = s.sx; flush_id = s.fl;
    rs1_id = s.r1; rs2_id = s.r2; rs1_used_id = s.u1; rs2_used_id = s.u2;
    rd_id = s.rd; reg_we_id = s.we; load_inst_id = s.ld;
    alu_a_sel = s.asel; alu_b_sel = s.bsel; store_inst_id = s.st; branch_inst_id = s.br;
  endtask

  function automatic bit writes_reg(input int i, input int k, input logic [4:0] r);
    return m_vld[i][k] && m_we[i][k] && (m_rd[i][k] != 5'd0) && (m_rd[i][k] == r);
  endfunction

  task automatic settle_eval();
    #1;
    for (int i = 0; i < 2; i++) begin
      int s1;
      int s2;
      bit haz;
      s1 = 0;
      s2 = 0;
      for (int k = 1; k <= 3; k++) begin
        if (s1 == 0 && rs1_used_id && writes_reg(i, k, rs1_id)) s1 = k;
        if (s2 == 0 && rs2_used_id && writes_reg(i, k, rs2_id)) s2 = k;
      end
      haz = (s1 != 0 && m_ld[i][s1] && s1 < m_lat[i]) || (s2 != 0 && m_ld[i][s2] && s2 < m_lat[i]);
      m_st[i] = haz && !flush_id;
      if (m_st[i]) exp_out[i] = 9'b0_0000_0001;
      else exp_out[i] = {alu_a_sel ? 2'd0 : 2'(s1), alu_b_sel ? 2'd0 : 2'(s2),
                         branch_inst_id ? 2'(s1) : 2'd0,
                         (store_inst_id || branch_inst_id) ? 2'(s2) : 2'd0, 1'b0};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 1; k <= 3; k++) m_vld[i][k] = 1'b0;
        m_cnt[i] = 0;
      end else if (!stall_ext) begin
        if (m_st[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
        for (int k = 3; k >= 2; k--) begin
          m_vld[i][k] = m_vld[i][k-1]; m_rd[i][k] = m_rd[i][k-1];
          m_we[i][k] = m_we[i][k-1]; m_ld[i][k] = m_ld[i][k-1];
        end
        if (m_st[i] || flush_id) m_vld[i][1] = 1'b0;
        else begin
          m_vld[i][1] = 1'b1; m_rd[i][1] = rd_id; m_we[i][1] = reg_we_id; m_ld[i][1] = load_inst_id;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t s;
    s = op(5'd5, 5'd6, 1, 1, 5'd5, 1, 1, 0, 0, 0, 1);
    s.rs = 1'b1;
    apply(s); settle_eval(); tick();
    settle_eval(); tick();
    apply(op(5'd5, 5'd6, 1, 1, 5'd0, 0, 0, 0, 0, 1, 1));
    settle_eval();
    n_check++; if (obs_a !== 9'd0) begin n_fail++; $display("[TB] FAIL reset out_A: got %b expected %b", obs_a, 9'd0); end
    n_check++; if (obs_b !== 9'd0) begin n_fail++; $display("[TB] FAIL reset out_B: got %b expected %b", obs_b, 9'd0); end
    n_check++; if (a_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset cnt_A: got %0d expected 0", a_cnt); end
    n_check++; if (b_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL reset cnt_B: got %0d expected 0", b_cnt); end
    tick();
  endtask

  task automatic test_forward_basic();
    stim_t seq[$];
    seq.push_back(op(5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0, 0, 0, 0));
    for (int n = 0; n < seq.size(); n++) begin
      apply(seq[n]); settle_eval();
      n_check++; if (obs_a !== exp_out[0]) begin n_fail++; $display("[TB] FAIL basic[%0d] out_A: got %b expected %b", n, obs_a, exp_out[0]); end
      n_check++; if (obs_b !== exp_out[1]) begin n_fail++; $display("[TB] FAIL basic[%0d] out_B: got %b expected %b", n, obs_b, exp_out[1]); end
      if (n == 1) begin
        n_check++; if ({a_fa, a_fb, a_st} !== 5'b01_01_0) begin n_fail++; $display("[TB] FAIL basic fwd_ab_stall: got %b expected 01010", {a_fa, a_fb, a_st}); end
      end
      tick();
    end
  endtask

  task automatic test_youngest();
    stim_t seq[$];
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd9, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd5, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd0, 5'd0, 1, 1, 5'd3, 1, 0, 0, 0, 1, 1));
    for (int n = 0; n < seq.size(); n++) begin
      apply(seq[n]); settle_eval();
      n_check++; if (obs_a !== exp_out[0]) begin n_fail++; $display("[TB] FAIL youngest[%0d] out_A: got %b expected %b", n, obs_a, exp_out[0]); end
      n_check++; if (obs_b !== exp_out[1]) begin n_fail++; $display("[TB] FAIL youngest[%0d] out_B: got %b expected %b", n, obs_b, exp_out[1]); end
      if (n == 3) begin
        n_check++; if ({a_fa, a_fb} !== 4'b0101) begin n_fail++; $display("[TB] FAIL youngest src: got %b expected 0101", {a_fa, a_fb}); end
      end
      if (n == 5) begin
        n_check++; if (obs_a !== 9'd0) begin n_fail++; $display("[TB] FAIL x0_nomatch out: got %b expected %b", obs_a, 9'd0); end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    seq.push_back(op(5'd2, 5'd0, 1, 0, 5'd7, 1, 1, 0, 1, 0, 0));
    for (int r = 0; r < 4; r++) seq.push_back(op(5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 0, 0, 0, 0));
    for (int n = 0; n < seq.size(); n++) begin
      apply(seq[n]); settle_eval();
      n_check++; if (obs_a !== exp_out[0]) begin n_fail++; $display("[TB] FAIL load_use[%0d] out_A: got %b expected %b", n, obs_a, exp_out[0]); end
      n_check++; if (obs_b !== exp_out[1]) begin n_fail++; $display("[TB] FAIL load_use[%0d] out_B: got %b expected %b", n, obs_b, exp_out[1]); end
      n_check++; if (a_cnt !== m_cnt[0][31:0]) begin n_fail++; $display("[TB] FAIL load_use[%0d] cnt_A: got %0d expected %0d", n, a_cnt, m_cnt[0]); end
      n_check++; if (b_cnt !== m_cnt[1][2:0]) begin n_fail++; $display("[TB] FAIL load_use[%0d] cnt_B: got %0d expected %0d", n, b_cnt, m_cnt[1]); end
      if (n == 1) begin
        n_check++; if ({a_st, b_st} !== 2'b11) begin n_fail++; $display("[TB] FAIL load_use stall1: got %b expected 11", {a_st, b_st}); end
      end
      if (n == 2) begin
        n_check++; if ({a_st, a_fa, b_st} !== 4'b0_10_1) begin n_fail++; $display("[TB] FAIL load_use step2: got %b expected 0101", {a_st, a_fa, b_st}); end
      end
      if (n == 3) begin
        n_check++; if ({b_st, b_fa} !== 3'b0_11) begin n_fail++; $display("[TB] FAIL load_use ll3 src: got %b expected 011", {b_st, b_fa}); end
      end
      tick();
    end
  endtask

  task automatic test_branch_store();
    stim_t seq[$];
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd6, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd5, 5'd6, 1, 1, 5'd0, 0, 0, 1, 1, 0, 1));
    seq.push_back(op(5'd1, 5'd5, 1, 1, 5'd0, 0, 0, 0, 1, 1, 0));
    for (int n = 0; n < seq.size(); n++) begin
      apply(seq[n]); settle_eval();
      n_check++; if (obs_a !== exp_out[0]) begin n_fail++; $display("[TB] FAIL br_st[%0d] out_A: got %b expected %b", n, obs_a, exp_out[0]); end
      n_check++; if (obs_b !== exp_out[1]) begin n_fail++; $display("[TB] FAIL br_st[%0d] out_B: got %b expected %b", n, obs_b, exp_out[1]); end
      if (n == 3) begin
        n_check++; if ({a_fa, a_fb, a_ba, a_bb} !== 8'b00_00_10_11) begin n_fail++; $display("[TB] FAIL branch srcs: got %b expected 00001011", {a_fa, a_fb, a_ba, a_bb}); end
      end
      if (n == 4) begin
        n_check++; if ({a_fb, a_bb} !== 4'b00_11) begin n_fail++; $display("[TB] FAIL store srcs: got %b expected 0011", {a_fb, a_bb}); end
      end
      tick();
    end
  endtask

  task automatic test_stall_ext_flush();
    stim_t seq[$];
    stim_t s;
    longint cnt_hold;
    cnt_hold = 0;
    seq.push_back(op(5'd2, 5'd0, 1, 0, 5'd7, 1, 1, 0, 1, 0, 0));
    for (int r = 0; r < 3; r++) begin
      s = op(5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 0, 0, 0, 0); s.sx = 1'b1; seq.push_back(s);
    end
    seq.push_back(op(5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd2, 5'd0, 1, 0, 5'd7, 1, 1, 0, 1, 0, 0));
    s = op(5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 0, 0, 0, 0); s.fl = 1'b1; seq.push_back(s);
    seq.push_back(op(5'd7, 5'd0, 1, 0, 5'd9, 1, 0, 0, 1, 0, 0));
    for (int n = 0; n < seq.size(); n++) begin
      apply(seq[n]); settle_eval();
      if (n == 1) cnt_hold = m_cnt[0];
      n_check++; if (obs_a !== exp_out[0]) begin n_fail++; $display("[TB] FAIL sx_fl[%0d] out_A: got %b expected %b", n, obs_a, exp_out[0]); end
      n_check++; if (obs_b !== exp_out[1]) begin n_fail++; $display("[TB] FAIL sx_fl[%0d] out_B: got %b expected %b", n, obs_b, exp_out[1]); end
      n_check++; if (a_cnt !== m_cnt[0][31:0]) begin n_fail++; $display("[TB] FAIL sx_fl[%0d] cnt_A: got %0d expected %0d", n, a_cnt, m_cnt[0]); end
      if (n >= 1 && n <= 4) begin
        n_check++; if ({a_st, a_cnt} !== {1'b1, cnt_hold[31:0]}) begin n_fail++; $display("[TB] FAIL sx_hold[%0d] stall/cnt: got %b/%0d expected 1/%0d", n, a_st, a_cnt, cnt_hold); end
      end
      if (n == 5) begin
        n_check++; if ({a_st, a_fa} !== 3'b0_10) begin n_fail++; $display("[TB] FAIL sx_release: got %b expected 010", {a_st, a_fa}); end
      end
      if (n == 7) begin
        n_check++; if (a_st !== 1'b0) begin n_fail++; $display("[TB] FAIL flush stall: got %b expected 0", a_st); end
      end
      if (n == 8) begin
        n_check++; if ({a_st, a_fa} !== 3'b0_10) begin n_fail++; $display("[TB] FAIL flush bubble: got %b expected 010", {a_st, a_fa}); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int n = 0; n < 400; n++) begin
      s = op(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
      s.rs = ($urandom_range(0, 49) == 0);
      s.sx = ($urandom_range(0, 5) == 0);
      s.fl = ($urandom_range(0, 7) == 0);
      apply(s); settle_eval();
      n_check++; if (obs_a !== exp_out[0]) begin n_fail++; $display("[TB] FAIL random[%0d] out_A: got %b expected %b", n, obs_a, exp_out[0]); end
      n_check++; if (obs_b !== exp_out[1]) begin n_fail++; $display("[TB] FAIL random[%0d] out_B: got %b expected %b", n, obs_b, exp_out[1]); end
      n_check++; if (a_cnt !== m_cnt[0][31:0]) begin n_fail++; $display("[TB] FAIL random[%0d] cnt_A: got %0d expected %0d", n, a_cnt, m_cnt[0]); end
      n_check++; if (b_cnt !== m_cnt[1][2:0]) begin n_fail++; $display("[TB] FAIL random[%0d] cnt_B: got %0d expected %0d", n, b_cnt, m_cnt[1]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    stim_t seq[$];
    stim_t s;
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd6, 1, 0, 0, 0, 0, 0));
    seq.push_back(op(5'd1, 5'd2, 0, 0, 5'd7, 1, 1, 0, 0, 0, 0));
    s = op(5'd5, 5'd6, 1, 1, 5'd0, 0, 0, 0, 0, 0, 1); s.rs = 1'b1; seq.push_back(s);
    seq.push_back(op(5'd5, 5'd7, 1, 1, 5'd0, 0, 0, 0, 0, 0, 1));
    for (int n = 0; n < seq.size(); n++) begin
      apply(seq[n]); settle_eval();
      n_check++; if (obs_a !== exp_out[0]) begin n_fail++; $display("[TB] FAIL rst_mid[%0d] out_A: got %b expected %b", n, obs_a, exp_out[0]); end
      n_check++; if (obs_b !== exp_out[1]) begin n_fail++; $display("[TB] FAIL rst_mid[%0d] out_B: got %b expected %b", n, obs_b, exp_out[1]); end
      if (n == 4) begin
        n_check++; if ({obs_a, obs_b, a_cnt, b_cnt} !== 53'd0) begin n_fail++; $display("[TB] FAIL rst_mid clear: got %b %b %0d %0d expected all zero", obs_a, obs_b, a_cnt, b_cnt); end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    stim_t seq[$];
    for (int r = 0; r < 8; r++) begin
      seq.push_back(op(5'd2, 5'd0, 1, 0, 5'd7, 1, 1, 0, 1, 0, 0));
      for (int j = 0; j < 3; j++) seq.push_back(op(5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 0, 0, 0, 0));
    end
    seq.push_back(op(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < seq.size(); n++) begin
      apply(seq[n]); settle_eval();
      n_check++; if (obs_b !== exp_out[1]) begin n_fail++; $display("[TB] FAIL sat[%0d] out_B: got %b expected %b", n, obs_b, exp_out[1]); end
      n_check++; if (b_cnt !== m_cnt[1][2:0]) begin n_fail++; $display("[TB] FAIL sat[%0d] cnt_B: got %0d expected %0d", n, b_cnt, m_cnt[1]); end
      if (n == seq.size() - 1) begin
        n_check++; if (b_cnt !== 3'b111) begin n_fail++; $display("[TB] FAIL sat final cnt_B: got %0d expected 7", b_cnt); end
        n_check++; if (a_cnt !== 32'd8) begin n_fail++; $display("[TB] FAIL sat final cnt_A: got %0d expected 8", a_cnt); end
      end
      tick();
    end
  endtask

  initial begin
    n_check = 0;
    n_fail  = 0;
    m_lat[0] = 2; m_lat[1] = 3;
    m_max[0] = 64'hFFFF_FFFF; m_max[1] = 7;
    m_cnt[0] = 0; m_cnt[1] = 0;
    apply(op(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_forward_basic();
    test_youngest();
    test_load_use();
    test_branch_store();
    test_stall_ext_flush();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
